// File: rtl/serial_add_ctrl_if.sv
// Bundle between the serial-add sequencer, its requester and the external up_counter.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface serial_add_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int WIDTH = 16
);
  logic             start;
  logic [CNT_W:0]   len;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_load;
  logic             cnt_tc;
  logic             sum_bit;
  logic             sum_bit_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             err;

  modport master (
    output start, len, a, b, cin, cnt_tc,
    input  cnt_val, cnt_load, sum_bit, sum_bit_valid, busy, done, sum, cout, err
  );

  modport slave (
    input  start, len, a, b, cin, cnt_tc,
    output cnt_val, cnt_load, sum_bit, sum_bit_valid, busy, done, sum, cout, err
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: loads an external up_counter with 16-len, adds LSB first
// one bit per clock until terminal count, then presents the right-aligned sum and carry.
module serial_add_ctrl #(
  parameter int CNT_W = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);
  localparam int LW = CNT_W + 1;
  localparam logic [LW-1:0] W_L = LW'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             c_q, c_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_val_q, cnt_val_d;
  logic             cnt_load_q, cnt_load_d;
  logic             sum_bit_q, sum_bit_d;
  logic             sum_bit_valid_q, sum_bit_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic             s;
  logic             c_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] sum_sh_nxt;
  logic [LW-1:0]    cnt_nxt;
  logic [LW-1:0]    len_gap;
  logic             len_ok;

  always_comb begin
    state_d         = state_q;
    a_sh_d          = a_sh_q;
    b_sh_d          = b_sh_q;
    sum_sh_d        = sum_sh_q;
    c_d             = c_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    cnt_val_d       = cnt_val_q;
    cnt_load_d      = 1'b0;
    sum_bit_d       = 1'b0;
    sum_bit_valid_d = 1'b0;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    sum_d           = sum_q;
    cout_d          = cout_q;
    err_d           = 1'b0;

    s          = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    c_nxt      = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    a_nxt      = a_sh_q >> 1;
    b_nxt      = b_sh_q >> 1;
    sum_sh_nxt = {s, sum_sh_q[WIDTH-1:1]};
    cnt_nxt    = cnt_q + LW'(1);
    len_gap    = W_L - bus.len;
    len_ok     = (bus.len != '0) && (bus.len <= W_L);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            a_sh_d     = bus.a;
            b_sh_d     = bus.b;
            c_d        = bus.cin;
            len_d      = bus.len;
            cnt_d      = '0;
            sum_sh_d   = '0;
            cnt_val_d  = len_gap[CNT_W-1:0];
            cnt_load_d = 1'b1;
            busy_d     = 1'b1;
            state_d    = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // Sum output is registered, so the first bit is prepared while the counter loads.
        busy_d          = 1'b1;
        sum_bit_d       = s;
        sum_bit_valid_d = 1'b1;
        state_d         = S_RUN;
      end
      S_RUN: begin
        a_sh_d   = a_nxt;
        b_sh_d   = b_nxt;
        c_d      = c_nxt;
        sum_sh_d = sum_sh_nxt;
        cnt_d    = cnt_nxt;
        if (bus.cnt_tc || (cnt_nxt == len_q)) begin
          done_d  = 1'b1;
          err_d   = !(bus.cnt_tc && (cnt_nxt == len_q));
          sum_d   = sum_sh_nxt >> (W_L - len_q);
          cout_d  = c_nxt;
          state_d = S_DONE;
        end else begin
          busy_d          = 1'b1;
          sum_bit_d       = a_nxt[0] ^ b_nxt[0] ^ c_nxt;
          sum_bit_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      a_sh_q          <= '0;
      b_sh_q          <= '0;
      sum_sh_q        <= '0;
      c_q             <= 1'b0;
      len_q           <= '0;
      cnt_q           <= '0;
      cnt_val_q       <= '0;
      cnt_load_q      <= 1'b0;
      sum_bit_q       <= 1'b0;
      sum_bit_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      sum_q           <= '0;
      cout_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      a_sh_q          <= a_sh_d;
      b_sh_q          <= b_sh_d;
      sum_sh_q        <= sum_sh_d;
      c_q             <= c_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      cnt_val_q       <= cnt_val_d;
      cnt_load_q      <= cnt_load_d;
      sum_bit_q       <= sum_bit_d;
      sum_bit_valid_q <= sum_bit_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      sum_q           <= sum_d;
      cout_q          <= cout_d;
      err_q           <= err_d;
    end
  end

  assign bus.cnt_val       = cnt_val_q;
  assign bus.cnt_load      = cnt_load_q;
  assign bus.sum_bit       = sum_bit_q;
  assign bus.sum_bit_valid = sum_bit_valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.sum           = sum_q;
  assign bus.cout          = cout_q;
  assign bus.err           = err_q;
endmodule
